// File: rtl/pixel_plot_sink_pkg.sv
// ---------------------------------------------------------------------------
// pixel_plot_sink_pkg
//  Shared definitions for the sprite pixel sink: screen geometry, field
//  widths, the packed pixel record that travels through the FIFO, the
//  frame-tracking FSM encoding and a saturating counter helper.
// ---------------------------------------------------------------------------
package pixel_plot_sink_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  // One buffered pixel; x is the most significant field.
  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } plot_state_t;

  // Increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pixel_plot_sink_pixel_fifo.sv
// ---------------------------------------------------------------------------
// pixel_fifo
//  Synchronous first-word-fall-through FIFO. The head entry is visible on
//  'head' whenever 'empty' is low, so the consumer can register it in the
//  same cycle it pops. Push is ignored when full, pop is ignored when empty.
//  Push and pop in the same cycle leave the count unchanged.
// Ports
//  CLOCK_50   in   1      clock, all state on posedge
//  reset      in   1      asynchronous, active-low; empties the FIFO
//  push       in   1      write push_data at the tail
//  push_data  in   WIDTH  entry to write
//  pop        in   1      discard the head entry
//  head       out  WIDTH  current head entry (valid when !empty)
//  full       out  1      DEPTH entries stored
//  empty      out  1      no entries stored
//  count      out  CW     number of stored entries
// ---------------------------------------------------------------------------
module pixel_fifo #(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == DEPTH[CW-1:0]);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage carries no reset: stale data is unreachable once the pointers clear.
  always_ff @(posedge CLOCK_50) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  assign head = mem[rd_ptr_reg];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pixel_plot_sink.sv
// ---------------------------------------------------------------------------
// pixel_plot_sink
//  Receiving end of the sprite pixel stream. Two drawers (s0 = bird,
//  s1 = hunter) offer pixels over valid/ready; a round-robin arbiter accepts
//  at most one per cycle. Off-screen pixels are counted and dropped, the rest
//  are buffered in pixel_fifo and replayed to vga_adapter one per clock.
//  A small FSM tracks the frame: once both sources have delivered their last
//  pixel and every buffered pixel has been plotted, frame_drawn pulses.
// Ports
//  CLOCK_50     in   1  system clock
//  reset        in   1  asynchronous, active-low
//  frame_start  in   1  pulse, opens a new frame collection
//  s0_valid     in   1  source 0 pixel valid
//  s0_ready     out  1  source 0 pixel accepted when valid & ready
//  s0_x/y/colour in  8/7/3  source 0 pixel
//  s0_last      in   1  final pixel of source 0's sprite
//  s1_*                 same set for source 1
//  vga_x/y/colour out 8/7/3 registered pixel to vga_adapter
//  vga_plot     out  1  write strobe, one cycle per pixel
//  frame_drawn  out  1  pulse, frame complete
//  clip_count   out  8  off-screen pixels dropped since reset, saturating
// ---------------------------------------------------------------------------
module pixel_plot_sink
  import pixel_plot_sink_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int X_MAX      = SCREEN_W,
  parameter int Y_MAX      = SCREEN_H
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                frame_start,
  input  logic                s0_valid,
  output logic                s0_ready,
  input  logic [X_W-1:0]      s0_x,
  input  logic [Y_W-1:0]      s0_y,
  input  logic [COLOUR_W-1:0] s0_colour,
  input  logic                s0_last,
  input  logic                s1_valid,
  output logic                s1_ready,
  input  logic [X_W-1:0]      s1_x,
  input  logic [Y_W-1:0]      s1_y,
  input  logic [COLOUR_W-1:0] s1_colour,
  input  logic                s1_last,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                frame_drawn,
  output logic [7:0]          clip_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // One extra bit so limits up to 2**W compare cleanly.
  localparam logic [X_W:0] X_LIM = X_MAX[X_W:0];
  localparam logic [Y_W:0] Y_LIM = Y_MAX[Y_W:0];

  // ---------------------------------------------------------------------
  // Source-side signals, gathered into arrays indexed by source number
  // ---------------------------------------------------------------------
  logic   [1:0] src_valid;
  logic   [1:0] src_last;
  logic   [1:0] src_sel;
  logic   [1:0] src_take;
  logic   [1:0] src_off;
  pixel_t       src_pix [2];

  assign src_valid  = {s1_valid, s0_valid};
  assign src_last   = {s1_last, s0_last};
  assign src_pix[0] = {s0_x, s0_y, s0_colour};
  assign src_pix[1] = {s1_x, s1_y, s1_colour};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic                run_reg;      // low during reset and the first cycle after
  logic                rr_pri_reg;   // source that wins a tie (0 = s0)
  logic [7:0]          clip_count_reg;
  logic [X_W-1:0]      vga_x_reg;
  logic [Y_W-1:0]      vga_y_reg;
  logic [COLOUR_W-1:0] vga_colour_reg;
  logic                vga_plot_reg;
  plot_state_t         state_reg;
  logic [1:0]          done_reg;
  logic                frame_drawn_reg;

  // FIFO interface
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  pixel_t              fifo_head;
  logic                fifo_push;
  logic                fifo_pop;

  // Accepted-pixel view
  logic                grant_ok;
  logic                acc_any;
  logic                acc_clip;
  logic [1:0]          acc_last;
  pixel_t              acc_pix;

  // ---------------------------------------------------------------------
  // Round-robin arbiter. A lone valid source is always chosen; on a tie
  // the priority pointer decides. Only 'full' gates ready, never the
  // same-cycle pop, so ready has no path from the output side.
  // ---------------------------------------------------------------------
  assign src_sel[0] = src_valid[0] & (~src_valid[1] | ~rr_pri_reg);
  assign src_sel[1] = src_valid[1] & (~src_valid[0] |  rr_pri_reg);
  assign grant_ok   = run_reg & ~fifo_full;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_take[gi] = src_sel[gi] & grant_ok;
    assign src_off[gi]  = ({1'b0, src_pix[gi].x} >= X_LIM) |
                          ({1'b0, src_pix[gi].y} >= Y_LIM);
  end

  assign s0_ready = src_take[0];
  assign s1_ready = src_take[1];

  assign acc_any   = |src_take;
  assign acc_pix   = src_take[1] ? src_pix[1] : src_pix[0];
  assign acc_clip  = |(src_take & src_off);
  assign acc_last  = src_take & src_last;   // clipped pixels still count
  assign fifo_push = acc_any & ~acc_clip;
  assign fifo_pop  = ~fifo_empty;

  pixel_fifo #(
    .WIDTH ($bits(pixel_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (acc_pix),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ---------------------------------------------------------------------
  // Arbiter pointer, clip counter and output register. The head is
  // captured on the pop edge, so vga_plot is high the cycle after a pop
  // and vga_x/y/colour simply hold between plots.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      run_reg        <= 1'b0;
      rr_pri_reg     <= 1'b0;
      clip_count_reg <= '0;
      vga_x_reg      <= '0;
      vga_y_reg      <= '0;
      vga_colour_reg <= '0;
      vga_plot_reg   <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (src_take[0]) begin
        rr_pri_reg <= 1'b1;
      end else if (src_take[1]) begin
        rr_pri_reg <= 1'b0;
      end
      if (acc_clip) begin
        clip_count_reg <= sat_inc8(clip_count_reg);
      end
      vga_plot_reg <= fifo_pop;
      if (fifo_pop) begin
        vga_x_reg      <= fifo_head.x;
        vga_y_reg      <= fifo_head.y;
        vga_colour_reg <= fifo_head.colour;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM. frame_start always wins and reopens collection; a last
  // accepted in that same cycle belongs to the new frame. Outside
  // COLLECT, lasts are ignored. frame_drawn is high exactly while in DONE.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      done_reg        <= '0;
      frame_drawn_reg <= 1'b0;
    end else begin
      frame_drawn_reg <= 1'b0;
      if (frame_start) begin
        state_reg <= ST_COLLECT;
        done_reg  <= acc_last;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            state_reg <= ST_IDLE;
          end
          ST_COLLECT: begin
            done_reg <= done_reg | acc_last;
            if (&done_reg) begin
              state_reg <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            // Empty FIFO and no plot in flight: the last pixel is on screen.
            if ((fifo_count == '0) && !vga_plot_reg) begin
              state_reg       <= ST_DONE;
              frame_drawn_reg <= 1'b1;
            end
          end
          ST_DONE: begin
            state_reg <= ST_IDLE;
            done_reg  <= '0;
          end
          default: begin
            state_reg <= ST_IDLE;
            done_reg  <= '0;
          end
        endcase
      end
    end
  end

  assign vga_x       = vga_x_reg;
  assign vga_y       = vga_y_reg;
  assign vga_colour  = vga_colour_reg;
  assign vga_plot    = vga_plot_reg;
  assign frame_drawn = frame_drawn_reg;
  assign clip_count  = clip_count_reg;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// ---------------------------------------------------------------------------
// tb_pixel_plot_sink
//  Self-checking bench for pixel_plot_sink: a table of single-pixel vectors
//  plus hand-written sequences for arbitration, clipping, frames and reset.
// ---------------------------------------------------------------------------
module tb_pixel_plot_sink;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       frame_start = 1'b0;
  logic       s0_valid = 1'b0, s1_valid = 1'b0;
  logic       s0_ready, s1_ready;
  logic [7:0] s0_x = '0, s1_x = '0;
  logic [6:0] s0_y = '0, s1_y = '0;
  logic [2:0] s0_colour = '0, s1_colour = '0;
  logic       s0_last = 1'b0, s1_last = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       frame_drawn;
  logic [7:0] clip_count;

  always #10 CLOCK_50 = ~CLOCK_50;

  pixel_plot_sink dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .frame_start (frame_start),
    .s0_valid    (s0_valid),
    .s0_ready    (s0_ready),
    .s0_x        (s0_x),
    .s0_y        (s0_y),
    .s0_colour   (s0_colour),
    .s0_last     (s0_last),
    .s1_valid    (s1_valid),
    .s1_ready    (s1_ready),
    .s1_x        (s1_x),
    .s1_y        (s1_y),
    .s1_colour   (s1_colour),
    .s1_last     (s1_last),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .frame_drawn (frame_drawn),
    .clip_count  (clip_count)
  );

  int checks = 0;
  int errors = 0;

  // Output monitor: every plotted pixel and every frame_drawn cycle.
  logic [17:0] plot_q[$];
  int          fd_count = 0;
  int          fd_plot_at = 0;
  always @(negedge CLOCK_50) begin
    if (vga_plot === 1'b1) plot_q.push_back({vga_x, vga_y, vga_colour});
    if (frame_drawn === 1'b1) begin
      fd_count++;
      fd_plot_at = plot_q.size();
    end
  end

  logic [17:0] exp_q[$];

  typedef struct {
    bit         src;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    bit         plot;
    int         clips;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Compare plots recorded since 'base' against exp_q, then clear exp_q.
  task automatic cmp_seq(input string name, input int base);
    int n_act;
    int bad;
    n_act = plot_q.size() - base;
    bad = 0;
    checks++;
    if (n_act != exp_q.size()) bad = 1;
    else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (plot_q[base+i] !== exp_q[i]) bad = 1;
    end
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: got %0d plots expected %0d plots in acceptance order", name, n_act, exp_q.size());
    end
    exp_q.delete();
  endtask

  // Drive n0/n1 pixels from each source, advancing on handshake; accepted
  // on-screen pixels go to exp_q in acceptance order.
  task automatic run_streams(input int n0, input int n1, input bit last0, input bit last1);
    int i0, i1, budget, both;
    i0 = 0; i1 = 0; budget = 0; both = 0;
    while ((i0 < n0 || i1 < n1) && budget < 500) begin
      s0_valid = (i0 < n0); s0_x = 8'(i0 * 3 + 1); s0_y = 7'd30; s0_colour = 3'(i0);
      s0_last = last0 && (i0 == n0 - 1);
      s1_valid = (i1 < n1); s1_x = 8'(80 + i1); s1_y = 7'd60; s1_colour = 3'(7 - i1);
      s1_last = last1 && (i1 == n1 - 1);
      #1;
      if (s0_ready && s1_ready) both++;
      if (s0_valid && s0_ready) begin exp_q.push_back({s0_x, s0_y, s0_colour}); i0++; end
      if (s1_valid && s1_ready) begin exp_q.push_back({s1_x, s1_y, s1_colour}); i1++; end
      tick();
      budget++;
    end
    s0_valid = 1'b0; s1_valid = 1'b0; s0_last = 1'b0; s1_last = 1'b0;
    chk("stream_done_in_budget", (budget < 500), 1);
    chk("stream_single_grant", both, 0);
  endtask

  task automatic send_one(input bit src, input logic [7:0] x, input logic [6:0] y,
                          input logic [2:0] c, input bit last);
    int n;
    bit got;
    n = 0; got = 0;
    if (src) begin s1_valid = 1; s1_x = x; s1_y = y; s1_colour = c; s1_last = last; end
    else     begin s0_valid = 1; s0_x = x; s0_y = y; s0_colour = c; s0_last = last; end
    while (!got && n < 50) begin
      #1;
      if ((src ? s1_ready : s0_ready) === 1'b1) got = 1;
      tick();
      n++;
    end
    s0_valid = 0; s1_valid = 0; s0_last = 0; s1_last = 0;
    chk("send_one_accepted", got, 1);
  endtask

  task automatic wait_frame(input int max_cycles);
    int n;
    n = 0;
    while (fd_count == 0 && n < max_cycles) begin tick(); n++; end
  endtask

  initial begin
    int base, acc, clip_model, fd_base, i0, i1;

    // ---------------- Reset state ----------------
    s0_valid = 1; s1_valid = 1; s0_x = 8'd3; s1_x = 8'd4;
    repeat (3) tick();
    chk("rst_s0_ready", s0_ready, 0);
    chk("rst_s1_ready", s1_ready, 0);
    chk("rst_vga_plot", vga_plot, 0);
    chk("rst_vga_xyc", {vga_x, vga_y, vga_colour}, 0);
    chk("rst_frame_drawn", frame_drawn, 0);
    chk("rst_clip_count", clip_count, 0);
    s0_valid = 0; s1_valid = 0;
    reset = 1'b1;
    repeat (2) tick();
    chk("post_rst_no_plot", plot_q.size(), 0);

    // ---------------- Table vectors ----------------
    vecs[0] = '{0, 8'd5,   7'd10,  3'd4, 1'b1, 0};
    vecs[1] = '{1, 8'd0,   7'd0,   3'd1, 1'b1, 0};
    vecs[2] = '{0, 8'd159, 7'd119, 3'd7, 1'b1, 0};
    vecs[3] = '{1, 8'd160, 7'd0,   3'd2, 1'b0, 1};
    vecs[4] = '{0, 8'd0,   7'd120, 3'd6, 1'b0, 2};
    vecs[5] = '{1, 8'hFF,  7'h7F,  3'd0, 1'b0, 3};
    vecs[6] = '{0, 8'd0,   7'd119, 3'd5, 1'b1, 3};
    vecs[7] = '{1, 8'd159, 7'd0,   3'd3, 1'b1, 3};
    begin
      logic [7:0] last_x;
      last_x = 8'd0;
      for (int i = 0; i < 8; i++) begin
        if (vecs[i].src) begin s1_valid = 1; s1_x = vecs[i].x; s1_y = vecs[i].y; s1_colour = vecs[i].c; end
        else             begin s0_valid = 1; s0_x = vecs[i].x; s0_y = vecs[i].y; s0_colour = vecs[i].c; end
        #1;
        chk($sformatf("vec%0d_ready", i), vecs[i].src ? s1_ready : s0_ready, 1);
        tick();
        s0_valid = 0; s1_valid = 0;
        chk($sformatf("vec%0d_plot_n1", i), vga_plot, 0);
        tick();
        chk($sformatf("vec%0d_plot_n2", i), vga_plot, vecs[i].plot);
        if (vecs[i].plot) begin
          chk($sformatf("vec%0d_xyc", i), {vga_x, vga_y, vga_colour}, {vecs[i].x, vecs[i].y, vecs[i].c});
          last_x = vecs[i].x;
        end else begin
          chk($sformatf("vec%0d_x_hold", i), vga_x, last_x);
        end
        chk($sformatf("vec%0d_clip_count", i), clip_count, vecs[i].clips);
        tick();
        chk($sformatf("vec%0d_plot_n3", i), vga_plot, 0);
      end
    end
    clip_model = 3;

    // ---------------- Contention: round robin from s0 ----------------
    base = plot_q.size();
    i0 = 0; i1 = 0;
    for (int k = 0; k < 6; k++) begin
      s0_valid = 1; s0_x = 8'(10 + i0); s0_y = 7'd20; s0_colour = 3'd1;
      s1_valid = 1; s1_x = 8'(100 + i1); s1_y = 7'd50; s1_colour = 3'd2;
      #1;
      chk($sformatf("rr%0d_s0_ready", k), s0_ready, (k % 2 == 0));
      chk($sformatf("rr%0d_s1_ready", k), s1_ready, (k % 2 == 1));
      if (k % 2 == 0) exp_q.push_back({8'(10 + k / 2), 7'd20, 3'd1});
      else            exp_q.push_back({8'(100 + k / 2), 7'd50, 3'd2});
      if (s0_ready) i0++;
      if (s1_ready) i1++;
      tick();
    end
    s0_valid = 0; s1_valid = 0;
    repeat (4) tick();
    cmp_seq("rr_plot_order", base);

    // ---------------- Clipped last still completes the frame ----------------
    fd_base = fd_count;
    base = plot_q.size();
    pulse_frame_start();
    send_one(1, 8'hFF, 7'h7F, 3'd0, 1);
    clip_model++;
    send_one(0, 8'd7, 7'd8, 3'd3, 1);
    wait_frame(60);
    repeat (5) tick();
    chk("cliplast_frame_pulses", fd_count - fd_base, 1);
    chk("cliplast_plots", plot_q.size() - base, 1);
    chk("cliplast_clip_count", clip_count, clip_model);

    // ---------------- Clip saturation ----------------
    base = plot_q.size();
    s1_valid = 1; s1_x = 8'hFF; s1_y = 7'h7F; s1_colour = 3'd0; s1_last = 0;
    acc = 0;
    for (int k = 0; k < 100; k++) begin #1; if (s1_ready) acc++; tick(); end
    chk("clip_after_100", clip_count, (clip_model + acc > 255) ? 255 : clip_model + acc);
    for (int k = 0; k < 200; k++) begin #1; if (s1_ready) acc++; tick(); end
    s1_valid = 0;
    tick();
    chk("clip_accepted_300", acc, 300);
    chk("clip_saturated", clip_count, 255);
    chk("clip_no_plot", plot_q.size() - base, 0);

    // ---------------- Back-to-back 12 pixels ----------------
    base = plot_q.size();
    run_streams(12, 0, 0, 0);
    repeat (4) tick();
    chk("b2b_count", plot_q.size() - base, 12);
    cmp_seq("b2b_order", base);

    // ---------------- Full frame, 13 pixels per source ----------------
    fd_base = fd_count;
    base = plot_q.size();
    pulse_frame_start();
    run_streams(13, 13, 1, 1);
    wait_frame(100);
    repeat (10) tick();
    chk("frame_pulse_count", fd_count - fd_base, 1);
    chk("frame_pulse_after_26", fd_plot_at - base, 26);
    cmp_seq("frame_plot_order", base);

    // ---------------- frame_start mid-COLLECT ----------------
    fd_base = fd_count;
    base = plot_q.size();
    pulse_frame_start();
    run_streams(5, 3, 1, 0);
    repeat (3) tick();
    pulse_frame_start();
    repeat (10) tick();
    chk("restart_no_pulse_a", fd_count - fd_base, 0);
    run_streams(1, 0, 1, 0);
    repeat (10) tick();
    chk("restart_no_pulse_b", fd_count - fd_base, 0);
    run_streams(0, 1, 0, 1);
    wait_frame(60);
    repeat (5) tick();
    chk("restart_single_pulse", fd_count - fd_base, 1);
    cmp_seq("restart_plot_order", base);

    // ---------------- Asynchronous reset mid-stream ----------------
    fd_base = fd_count;
    pulse_frame_start();
    s0_valid = 1; s0_y = 7'd40; s0_colour = 3'd6;
    for (int k = 0; k < 3; k++) begin
      s0_x = 8'(20 + k);
      #1;
      tick();
    end
    reset = 1'b0;
    base = plot_q.size();
    #2;
    chk("arst_vga_plot", vga_plot, 0);
    chk("arst_vga_xyc", {vga_x, vga_y, vga_colour}, 0);
    chk("arst_clip_count", clip_count, 0);
    chk("arst_frame_drawn", frame_drawn, 0);
    chk("arst_s0_ready", s0_ready, 0);
    repeat (3) tick();
    chk("arst_hold_s0_ready", s0_ready, 0);
    s0_valid = 0;
    reset = 1'b1;
    repeat (6) tick();
    chk("arst_fifo_discarded", plot_q.size() - base, 0);
    chk("arst_no_frame", fd_count - fd_base, 0);
    base = plot_q.size();
    run_streams(1, 0, 0, 0);
    repeat (4) tick();
    cmp_seq("arst_recovery_plot", base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
